// File: rtl/audio_serializer.sv
// audio_serializer: latches one 24-bit signed sample per frame and serializes
// it MSB first onto the codec DAC pins (BCLK, DACLRCK, DACDAT). The same
// sample is sent in the left and the right slot (mono). One frame is 64 BCLK
// periods and each BCLK half-period is BCLK_DIV clk cycles.
//
// Build option: define AUDIO_SERIALIZER_I2S_DELAY_EN for I2S format, where
// the MSB follows each LRCK edge by one BCLK. Leave it undefined for
// left-justified format, where the MSB is coincident with each LRCK edge.
module audio_serializer #(
  parameter int BCLK_DIV = 8  // clk cycles per BCLK half-period, 2..255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [23:0] sample,
  output logic        sample_strobe,
  output logic        busy,
  output logic        aud_bclk,
  output logic        aud_daclrck,
  output logic        aud_dacdat
);

`ifdef AUDIO_SERIALIZER_I2S_DELAY_EN
  localparam logic [5:0] SLOT_DELAY = 6'd1;
`else
  localparam logic [5:0] SLOT_DELAY = 6'd0;
`endif

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_div_cnt;
  logic        r_bclk;
  logic [5:0]  r_bit_cnt;
  logic [23:0] r_hold;
  logic [23:0] r_shift;
  logic        r_dacdat;
  logic        r_strobe;

  logic        w_div_wrap;
  logic        w_fall;
  logic        w_frame_end;
  logic        w_frame_start;
  logic        w_to_idle;
  logic        w_update;
  logic [5:0]  w_bit_nxt;
  logic [23:0] w_slot_src;
  logic [5:0]  w_pos;
  logic        w_in_slot;
  logic        w_do_shift;
  logic [23:0] w_shift_nxt;
  logic        w_dacdat_nxt;

  // Divider wrap, BCLK fall event and the end-of-frame event (fall leaving bit 63).
  assign w_div_wrap  = (r_div_cnt == DIV_LAST);
  assign w_fall      = (r_state != S_IDLE) && w_div_wrap && r_bclk;
  assign w_frame_end = w_fall && (r_bit_cnt == 6'd63);

  // Next state and frame-start decision.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave it unassigned and infer a latch.
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_nxt   = S_RUN;
          w_frame_start = 1'b1;
        end
      end
      S_RUN: begin
        if (!en) w_state_nxt = S_DRAIN;
        if (w_frame_end) w_frame_start = 1'b1;
      end
      S_DRAIN: begin
        if (en) begin
          w_state_nxt   = S_RUN;
          w_frame_start = w_frame_end;
        end else if (w_frame_end) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    else          r_state <= w_state_nxt;
  end

  // Bit position, slot source and the next shift-register/data values.
  // A slot boundary (bit_cnt[4:0] == 0) reloads the shifter; a fresh frame
  // takes the incoming sample directly because hold is written on the same edge.
  assign w_to_idle    = (w_state_nxt == S_IDLE);
  assign w_update     = w_frame_start || w_fall;
  assign w_bit_nxt    = w_frame_start ? 6'd0 : (r_bit_cnt + 6'd1);
  assign w_slot_src   = w_frame_start ? sample : r_hold;
  assign w_pos        = {1'b0, w_bit_nxt[4:0]} - SLOT_DELAY;  // delay slot wraps to 63
  assign w_in_slot    = (w_pos <= 6'd23);
  assign w_do_shift   = w_in_slot && (w_pos != 6'd0);
  assign w_shift_nxt  = (w_bit_nxt[4:0] == 5'd0) ? w_slot_src
                      : (w_do_shift ? {r_shift[22:0], 1'b0} : r_shift);
  assign w_dacdat_nxt = w_in_slot && w_shift_nxt[23];

  // Divider, BCLK, bit counter, hold/shift registers and strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
      r_bit_cnt <= '0;
      r_hold    <= '0;
      r_shift   <= '0;
      r_dacdat  <= 1'b0;
      r_strobe  <= 1'b0;
    end else begin
      r_strobe <= w_frame_start;
      if (w_frame_start) r_hold <= sample;

      if (w_to_idle || (r_state == S_IDLE)) begin
        r_div_cnt <= '0;
        r_bclk    <= 1'b0;
      end else begin
        r_div_cnt <= w_div_wrap ? 8'd0 : (r_div_cnt + 8'd1);
        if (w_div_wrap) r_bclk <= ~r_bclk;
      end

      if (w_to_idle) begin
        r_bit_cnt <= '0;
        r_dacdat  <= 1'b0;
      end else if (w_update) begin
        r_bit_cnt <= w_bit_nxt;
        r_shift   <= w_shift_nxt;
        r_dacdat  <= w_dacdat_nxt;
      end
    end
  end

  assign sample_strobe = r_strobe;
  assign busy          = (r_state != S_IDLE);
  assign aud_bclk      = r_bclk;
  assign aud_daclrck   = r_bit_cnt[5];
  assign aud_dacdat    = r_dacdat;

endmodule

// File: tb/tb_audio_serializer.sv
// Self-checking bench for audio_serializer (BCLK_DIV = 4). Serial data and
// LRCK are captured on BCLK rising edges and compared against a frame model
// built directly from slot positions.
module tb_audio_serializer;

  localparam int BCLK_DIV  = 4;
  localparam int FRAME_CLK = 128 * BCLK_DIV;
`ifdef AUDIO_SERIALIZER_I2S_DELAY_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif
  localparam logic [63:0] LR_EXP = 64'hFFFF_FFFF_0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [23:0] sample = '0;
  logic        sample_strobe;
  logic        busy;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic        aud_dacdat;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;

  audio_serializer #(.BCLK_DIV(BCLK_DIV)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .sample       (sample),
    .sample_strobe(sample_strobe),
    .busy         (busy),
    .aud_bclk     (aud_bclk),
    .aud_daclrck  (aud_daclrck),
    .aud_dacdat   (aud_dacdat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] smp;
    logic [23:0] exp_word;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference frame: bit i is what the codec captures on BCLK rise i.
  function automatic logic [63:0] model_frame(input logic [23:0] s);
    logic [63:0] f;
    int p;
    f = '0;
    for (int i = 0; i < 64; i++) begin
      p = (i % 32) - D;
      if (p >= 0 && p < 24) f[i] = s[23 - p];
    end
    return f;
  endfunction

  function automatic logic [4:0] outs();
    return {sample_strobe, busy, aud_bclk, aud_daclrck, aud_dacdat};
  endfunction

  task automatic wait_strobe(input int budget, output logic ok, output int unsigned when);
    ok = 1'b0;
    when = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sample_strobe) begin
        ok = 1'b1;
        when = cyc;
        return;
      end
    end
  endtask

  // Called at the negedge where the strobe is visible; captures 64 BCLK rises.
  task automatic capture_frame(input int off_at, input int on_at, input int chg_at,
                               input logic [23:0] chg_val,
                               output logic [63:0] bits, output logic [63:0] lr,
                               output int first_fall, output logic busy_dropped,
                               output logic ok);
    int   n;
    int   t;
    logic prev;
    n = 0;
    t = 0;
    prev = aud_bclk;
    bits = '0;
    lr = '0;
    first_fall = -1;
    busy_dropped = 1'b0;
    while (n < 64 && t < FRAME_CLK + 8) begin
      @(negedge clk);
      t++;
      if (!busy) busy_dropped = 1'b1;
      if (prev && !aud_bclk && first_fall < 0) first_fall = t;
      if (!prev && aud_bclk) begin
        bits[n] = aud_dacdat;
        lr[n]   = aud_daclrck;
        if (n == off_at) en = 1'b0;
        if (n == on_at)  en = 1'b1;
        if (n == chg_at) sample = chg_val;
        n++;
      end
      prev = aud_bclk;
    end
    ok = (n == 64);
  endtask

  initial begin
    vec_t        vecs[6];
    logic        ok;
    logic        bd;
    int unsigned t_prev;
    int unsigned t_now;
    logic [63:0] bits;
    logic [63:0] lr;
    logic [63:0] mask;
    logic [23:0] lw;
    logic [23:0] rw;
    logic [23:0] r;
    int          ff;
    int          viol;
    int          k_fall;

    vecs[0] = '{24'hA5C3F1, 24'hA5C3F1};
    vecs[1] = '{24'h000001, 24'h000001};
    vecs[2] = '{24'h800000, 24'h800000};
    vecs[3] = '{24'hFFFFFF, 24'hFFFFFF};
    vecs[4] = '{24'h7FFFFF, 24'h7FFFFF};
    vecs[5] = '{24'h5A5A5A, 24'h5A5A5A};
    mask = model_frame(24'hFFFFFF);

    // Reset with en high, release with en low: everything stays quiet.
    reset_n = 1'b0;
    en = 1'b1;
    sample = 24'hA5C3F1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(outs()), 64'd0);
    en = 1'b0;
    reset_n = 1'b1;
    viol = 0;
    repeat (5000) begin
      @(negedge clk);
      if (outs() != 5'd0) viol++;
    end
    check("idle_quiet", 64'(viol), 64'd0);

    // RUN entry: strobe and MSB (left-justified) on the first RUN clk.
    en = 1'b1;
    @(negedge clk);
    t_prev = cyc;
    bits = model_frame(24'hA5C3F1);
    check("entry_strobe", 64'(sample_strobe), 64'd1);
    check("entry_busy", 64'(busy), 64'd1);
    check("entry_dacdat", 64'(aud_dacdat), 64'(bits[0]));
    capture_frame(-1, -1, -1, 24'h0, bits, lr, ff, bd, ok);
    check("entry_capture_done", 64'(ok), 64'd1);
    check("entry_first_fall", 64'(ff), 64'(2 * BCLK_DIV));
    check("entry_frame", bits, model_frame(24'hA5C3F1));
    check("entry_lrck", lr, LR_EXP);

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      sample = vecs[v].smp;
      wait_strobe(3 * BCLK_DIV, ok, t_now);
      check("vec_strobe", 64'(ok), 64'd1);
      check("vec_period", 64'(t_now - t_prev), 64'(FRAME_CLK));
      t_prev = t_now;
      capture_frame(-1, -1, -1, 24'h0, bits, lr, ff, bd, ok);
      for (int p = 0; p < 24; p++) begin
        lw[23 - p] = bits[D + p];
        rw[23 - p] = bits[32 + D + p];
      end
      check("vec_left", 64'(lw), 64'(vecs[v].exp_word));
      check("vec_right", 64'(rw), 64'(vecs[v].exp_word));
      check("vec_pad_zero", bits & ~mask, 64'd0);
      check("vec_lrck", lr, LR_EXP);
    end

    // Mid-frame sample change only affects the next frame.
    sample = 24'hA5C3F1;
    wait_strobe(3 * BCLK_DIV, ok, t_now);
    t_prev = t_now;
    capture_frame(-1, -1, 10, 24'h000001, bits, lr, ff, bd, ok);
    check("midchg_cur_frame", bits, model_frame(24'hA5C3F1));
    wait_strobe(3 * BCLK_DIV, ok, t_now);
    check("midchg_period", 64'(t_now - t_prev), 64'(FRAME_CLK));
    t_prev = t_now;
    capture_frame(-1, -1, -1, 24'h0, bits, lr, ff, bd, ok);
    check("midchg_next_frame", bits, model_frame(24'h000001));

    // Randomized frames with a random disturbance inside each frame.
    for (int k = 0; k < 6; k++) begin
      r = 24'($urandom);
      sample = r;
      wait_strobe(3 * BCLK_DIV, ok, t_now);
      check("rand_period", 64'(t_now - t_prev), 64'(FRAME_CLK));
      t_prev = t_now;
      capture_frame(-1, -1, int'($urandom_range(1, 62)), 24'($urandom), bits, lr, ff, bd, ok);
      check("rand_frame", bits, model_frame(r));
    end

    // Drain: en drops at bit 40, frame completes, then everything goes low.
    sample = 24'hC0FFEE;
    wait_strobe(3 * BCLK_DIV, ok, t_now);
    capture_frame(40, -1, -1, 24'h0, bits, lr, ff, bd, ok);
    check("drain_frame", bits, model_frame(24'hC0FFEE));
    check("drain_busy_held", 64'(bd), 64'd0);
    k_fall = -1;
    for (int k = 1; k <= 4 * BCLK_DIV; k++) begin
      @(negedge clk);
      if (!busy) begin
        k_fall = k;
        break;
      end
    end
    check("drain_busy_fall", 64'(k_fall), 64'(BCLK_DIV));
    check("drain_outputs_low", 64'(outs()), 64'd0);
    viol = 0;
    repeat (3 * FRAME_CLK) begin
      @(negedge clk);
      if (outs() != 5'd0) viol++;
    end
    check("drain_stays_idle", 64'(viol), 64'd0);

    // Drain cancelled at bit 50: frames continue with no gap.
    sample = 24'h123456;
    en = 1'b1;
    @(negedge clk);
    check("restart_strobe", 64'(sample_strobe), 64'd1);
    t_prev = cyc;
    capture_frame(40, 50, -1, 24'h0, bits, lr, ff, bd, ok);
    check("cancel_busy_held", 64'(bd), 64'd0);
    check("cancel_frame", bits, model_frame(24'h123456));
    wait_strobe(3 * BCLK_DIV, ok, t_now);
    check("cancel_strobe", 64'(ok), 64'd1);
    check("cancel_period", 64'(t_now - t_prev), 64'(FRAME_CLK));
    capture_frame(-1, -1, -1, 24'h0, bits, lr, ff, bd, ok);
    check("cancel_next_frame", bits, model_frame(24'h123456));

    // Async reset mid-frame (around bit 20).
    wait_strobe(3 * BCLK_DIV, ok, t_now);
    repeat (20 * 2 * BCLK_DIV + 2) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("reset_async_drop", 64'(outs()), 64'd0);
    repeat (3) @(negedge clk);
    check("reset_held_low", 64'(outs()), 64'd0);
    sample = 24'h0F0F0F;
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_strobe", 64'(sample_strobe), 64'd1);
    capture_frame(-1, -1, -1, 24'h0, bits, lr, ff, bd, ok);
    check("post_reset_frame", bits, model_frame(24'h0F0F0F));
    check("post_reset_lrck", lr, LR_EXP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
